uart_tx_fifo: RTL and testbench

//  Byte buffer that sits directly upstream of the UART transmitter. Accepts words

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_mem.sv | 30 +++
 rtl/uart_tx_fifo.sv | 111 +++++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmitter, its TX FIFO and the receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATABITS = 8;

  typedef logic [UART_DATABITS-1:0] uart_word_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x WIDTH register array, synchronous write port, asynchronous read port.
// Latency: write visible on rdata_o the cycle after the write edge; read is combinational.
// Backpressure: none; the owner guarantees it never writes a slot that is still unread.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATABITS,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word at the write pointer; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-entry buffer feeding the UART transmitter over a toggle handshake (tx_seq/tx_ack).
// Latency: word pushed at edge N into an empty FIFO with an idle transmitter toggles tx_seq at edge N+1.
// Backpressure: in_ready drops only when full; issue waits for tx_ack == tx_seq. UART_TX_FIFO_LEVEL_EN adds the level port.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATABITS = UART_DATABITS,
  parameter int DEPTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATABITS-1:0]     in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATABITS-1:0]     tx_data,
  output logic                    tx_seq,
  input  logic                    tx_ack
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q = '0;
  logic [CW-1:0]       count_d;
  logic [DATABITS-1:0] tx_data_q = '0;
  logic                tx_seq_q = 1'b0;
  logic [DATABITS-1:0] mem_rdata;

  logic push;
  logic busy;
  logic issue;

  // Ready depends only on the registered occupancy, so there is no combinational
  // path from in_valid or tx_ack to in_ready and no pass-through when full.
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready && !reset;

  // The transmitter is busy while it has not yet acknowledged the last toggle;
  // no explicit handshake state is kept beyond tx_seq itself.
  assign busy  = (tx_seq_q != tx_ack);
  assign issue = !reset && !busy && (count_q != '0);

  uart_fifo_mem #(
    .WIDTH (DATABITS),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state pointers and occupancy; a simultaneous push and issue leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset discards every queued word.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Hand the head word to the transmitter; tx_seq is deliberately left alone by
  // reset because the transmitter realigns its ack to seq on the same reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_data_q <= '0;
    end else if (issue) begin
      tx_data_q <= mem_rdata;
      tx_seq_q  <= ~tx_seq_q;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_seq  = tx_seq_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = count_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: uart_tx_fifo paired with a model transmitter that acks a set number of cycles after each toggle.
// Latency: n/a.
// Backpressure: model transmitter can be stalled to fill the FIFO.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_seq;
  logic       tx_ack = 1'b0;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATABITS (8),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_seq   (tx_seq),
    .tx_ack   (tx_ack)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: queue of accepted words, last handed word, sequence bit.
  byte unsigned mq[$];
  logic         m_seq  = 1'b0;
  logic [7:0]   m_data = 8'h00;

  // Model transmitter.
  int ack_delay = 1;
  bit stall     = 1'b0;
  int ack_cnt   = 0;
  int n_toggle  = 0;
  int n_ack     = 0;

  // Observation of the DUT's word stream.
  logic       prev_seq  = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] out_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, advance model and transmitter, compare outputs.
  task automatic step(input logic v, input logic [7:0] d);
    logic exp_rdy;
    logic push;
    logic issue;
    in_valid = v;
    in_data  = d;
    exp_rdy  = (mq.size() != DEPTH);
    chk("in_ready", in_ready, exp_rdy);
    push  = v && exp_rdy && !reset;
    issue = !reset && (m_seq == tx_ack) && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      m_data = 8'h00;
    end else begin
      if (issue) begin
        m_data = mq.pop_front();
        m_seq  = ~m_seq;
      end
      if (push) mq.push_back(d);
    end
    chk("tx_seq", tx_seq, m_seq);
    chk("tx_data", tx_data, m_data);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("level", level, mq.size());
`endif
    if (tx_seq !== prev_seq) begin
      out_log.push_back(tx_data);
      n_toggle++;
    end else if (!reset) begin
      chk("tx_data_hold", tx_data, prev_data);
    end
    prev_seq  = tx_seq;
    prev_data = tx_data;
    if (reset) begin
      tx_ack  = tx_seq;
      ack_cnt = 0;
    end else if ((tx_seq !== tx_ack) && !stall) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        tx_ack  = tx_seq;
        ack_cnt = 0;
        n_ack++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  initial begin
    int n_push;
    #1;
    // Power-up reset.
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_ready", in_ready, 1);
    chk("rst_seq_eq_ack", tx_seq === tx_ack, 1);
    chk("rst_data", tx_data, 0);

    // 1. Single word: toggle exactly one cycle after the push.
    ack_delay = 2;
    out_log.delete();
    step(1'b1, 8'hA5);
    chk("s1_no_toggle_yet", out_log.size(), 0);
    step(1'b0, 8'h00);
    chk("s1_toggle", out_log.size(), 1);
    if (out_log.size() == 1) chk("s1_word", out_log[0], 8'hA5);
    idle(4);

    // 2. Fill with the transmitter stalled, then drain in order.
    stall = 1'b1;
    out_log.delete();
    for (int i = 0; i < 18; i++) step(1'b1, 8'(i));
    chk("s2_full_ready", in_ready, 0);
    stall = 1'b0;
    ack_delay = 1;
    idle(60);
    chk("s2_count", out_log.size(), 17);
    for (int i = 0; i < out_log.size() && i < 17; i++) chk("s2_order", out_log[i], 8'(i));

    // 3. Ack delay 3 with continuous push of random data.
    ack_delay = 3;
    n_toggle  = 0;
    n_ack     = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom));
    chk("s3_toggle_per_ack", n_toggle, n_ack + ((tx_seq !== tx_ack) ? 1 : 0));
    idle(80);
    chk("s3_drained", tx_seq === tx_ack, 1);

    // 4. Hold count at 5 with simultaneous push/issue; pointers wrap.
    out_log.delete();
    stall  = 1'b1;
    n_push = 0;
    for (int i = 0; i < 20 && mq.size() < 5; i++) begin
      step(1'b1, 8'(8'h40 + n_push));
      n_push++;
    end
    stall = 1'b0;
    ack_delay = 1;
    for (int i = 0; i < 200 && n_push < 46; i++) begin
      if ((m_seq == tx_ack) && (mq.size() != 0)) begin
        step(1'b1, 8'(8'h40 + n_push));
        n_push++;
      end else begin
        step(1'b0, 8'h00);
      end
    end
    chk("s4_pushed", n_push, 46);
    idle(40);
    chk("s4_count", out_log.size(), n_push);
    for (int i = 0; i < out_log.size() && i < n_push; i++) chk("s4_order", out_log[i], 8'(8'h40 + i));

    // 5. Reset with 7 queued and one in flight.
    stall = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom));
    chk("s5_in_flight", tx_seq !== tx_ack, 1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    stall = 1'b0;
    chk("s5_ready", in_ready, 1);
    chk("s5_aligned", tx_seq === tx_ack, 1);
    chk("s5_data", tx_data, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("s5_level", level, 0);
`endif
    out_log.delete();
    idle(5);
    chk("s5_no_toggle", out_log.size(), 0);
    step(1'b1, 8'h3C);
    step(1'b0, 8'h00);
    chk("s5_next_word", out_log.size(), 1);
    if (out_log.size() == 1) chk("s5_next_val", out_log[0], 8'h3C);
    idle(4);

    // Random traffic with random ack delay.
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) ack_delay = int'($urandom_range(1, 4));
      step(1'($urandom_range(0, 1)), 8'($urandom));
    end
    idle(100);
    chk("rand_drained", tx_seq === tx_ack, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
